stim_sig_engine: RTL and testbench

STIM_SIG_ENGINE -- requirements
Module: stim_sig_engine

---
 rtl/stim_sig_engine.sv | 193 +++++++++++++++++++
 tb/tb_stim_sig_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stim_sig_engine.sv
// Vector-table stimulus engine: loads a table, replays it with hold/gap timing,
// and compacts the DUT response into a MISR signature checked against a golden value.
module stim_sig_engine #(
  parameter int               IN_W    = 76,
  parameter int               OUT_W   = 151,
  parameter int               DEPTH   = 32,
  parameter int               HOLD    = 2,
  parameter int               DUT_LAT = 1,
  parameter int               SIG_W   = 32,
  parameter logic [SIG_W-1:0] SEED    = {SIG_W{1'b1}},
  parameter logic [SIG_W-1:0] POLY    = 32'h04C11DB7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [IN_W-1:0]             ld_data,
  input  logic                        ld_last,
  input  logic                        start,
  input  logic                        gap_en,
  output logic [IN_W-1:0]             stim,
  input  logic [OUT_W-1:0]            dut_y,
  input  logic [SIG_W-1:0]            expect_sig,
  output logic                        busy,
  output logic                        done,
  output logic                        match,
  output logic [SIG_W-1:0]            sig,
  output logic [$clog2(DEPTH):0]      nvec
);

  localparam int       AW      = $clog2(DEPTH);
  localparam int       PW      = AW + 1;
  localparam int       HW      = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int       NSL     = (OUT_W + SIG_W - 1) / SIG_W;
  localparam logic [2:0] LAT_IDX = 3'(DUT_LAT);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

  // Zero-extend the response to whole SIG_W slices and XOR them together.
  function automatic logic [SIG_W-1:0] fold_resp(input logic [OUT_W-1:0] y);
    logic [NSL*SIG_W-1:0] ext;
    logic [SIG_W-1:0]     f;
    ext = {(NSL*SIG_W){1'b0}};
    ext[OUT_W-1:0] = y;
    f = {SIG_W{1'b0}};
    for (int k = 0; k < NSL; k++) f = f ^ ext[k*SIG_W +: SIG_W];
    return f;
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] f);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : {SIG_W{1'b0}}) ^ f;
  endfunction

  logic [IN_W-1:0]  r_table [DEPTH];
  state_t           r_state;
  logic [PW-1:0]    r_wr_ptr;
  logic             r_restart;
  logic [PW-1:0]    r_idx;
  logic [PW-1:0]    r_samp;
  logic [HW-1:0]    r_hold;
  logic             r_gap;
  logic [6:0]       r_pend;
  logic [IN_W-1:0]  r_stim;
  logic [SIG_W-1:0] r_sig;
  logic             r_busy;
  logic             r_done;
  logic             r_match;

  logic             w_beat;
  logic             w_restart;
  logic [PW-1:0]    w_wr_idx;
  logic [PW-1:0]    w_nxt_idx;
  logic             w_busy_st;
  logic             w_last_hold;
  logic             w_last_vec;
  logic [7:0]       w_taps;
  logic             w_sample;
  logic             w_final;
  logic [SIG_W-1:0] w_sig_next;

  assign ld_ready    = ((r_state == S_IDLE) && (r_wr_ptr < PW'(DEPTH))) || (r_state == S_DONE);
  assign w_beat      = ld_valid && ld_ready;
  // A finished load or a completed run makes the next beat start a fresh table.
  assign w_restart   = r_restart || (r_state == S_DONE);
  assign w_wr_idx    = w_restart ? {PW{1'b0}} : r_wr_ptr;
  assign w_nxt_idx   = r_idx + PW'(1);
  assign w_busy_st   = (r_state == S_RUN) || (r_state == S_GAP) || (r_state == S_DRAIN);
  assign w_last_hold = (r_state == S_RUN) && (r_hold == HW'(HOLD - 1));
  assign w_last_vec  = (r_idx == (r_wr_ptr - PW'(1)));
  // Tap k of this delay line marks the response window k cycles after a last hold.
  assign w_taps      = {r_pend, w_last_hold};
  assign w_sample    = w_busy_st && (|(w_taps & (8'b0000_0001 << LAT_IDX)));
  assign w_final     = w_sample && (r_samp == (r_wr_ptr - PW'(1)));
  assign w_sig_next  = misr_step(r_sig, fold_resp(dut_y));

  assign stim  = r_stim;
  assign sig   = r_sig;
  assign busy  = r_busy;
  assign done  = r_done;
  assign match = r_match;
  assign nvec  = r_wr_ptr;

  // Vector table storage; contents survive runs and are not reset.
  always_ff @(posedge clk) begin
    if (w_beat) r_table[w_wr_idx[AW-1:0]] <= ld_data;
  end

  // Control FSM with registered stimulus, signature and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= {PW{1'b0}};
      r_restart <= 1'b0;
      r_idx     <= {PW{1'b0}};
      r_samp    <= {PW{1'b0}};
      r_hold    <= {HW{1'b0}};
      r_gap     <= 1'b0;
      r_pend    <= 7'd0;
      r_stim    <= {IN_W{1'b0}};
      r_sig     <= SEED;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
    end else begin
      r_pend <= w_taps[6:0];
      if (w_sample) begin
        r_sig  <= w_sig_next;
        r_samp <= r_samp + PW'(1);
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_beat) begin
            r_wr_ptr  <= w_wr_idx + PW'(1);
            r_restart <= ld_last || ((w_wr_idx + PW'(1)) == PW'(DEPTH));
            r_done    <= 1'b0;
            r_match   <= 1'b0;
            r_state   <= S_IDLE;
          end else if (start && (r_wr_ptr != {PW{1'b0}})) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_match <= 1'b0;
            r_sig   <= SEED;
            r_idx   <= {PW{1'b0}};
            r_samp  <= {PW{1'b0}};
            r_hold  <= {HW{1'b0}};
            r_gap   <= gap_en;
            r_stim  <= r_table[{AW{1'b0}}];
          end
        end
        S_RUN: begin
          if (w_last_hold) begin
            r_hold <= {HW{1'b0}};
            if (w_last_vec) begin
              r_stim  <= {IN_W{1'b0}};
              r_state <= S_DRAIN;
            end else if (r_gap) begin
              r_stim  <= {IN_W{1'b0}};
              r_state <= S_GAP;
            end else begin
              r_idx  <= w_nxt_idx;
              r_stim <= r_table[w_nxt_idx[AW-1:0]];
            end
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        S_GAP: begin
          r_idx   <= w_nxt_idx;
          r_stim  <= r_table[w_nxt_idx[AW-1:0]];
          r_state <= S_RUN;
        end
        S_DRAIN: begin
          r_stim <= {IN_W{1'b0}};
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // The final sample closes the run regardless of which busy state it lands in.
      if (w_final) begin
        r_sig   <= w_sig_next;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_match <= (w_sig_next == expect_sig);
        r_stim  <= {IN_W{1'b0}};
        r_state <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_stim_sig_engine.sv
// Directed bench: two engines (DUT_LAT=0 with combinational loopback, DUT_LAT=3 with
// registered loopback) share load/start stimulus; signatures come from a bit-level MISR model.
module tb_stim_sig_engine;

  logic         clk;
  logic         rst_n;
  logic         ld_valid;
  logic [75:0]  ld_data;
  logic         ld_last;
  logic         start;
  logic         gap_en;
  logic [31:0]  expect0;
  logic [31:0]  expect3;

  logic         ld_ready0, busy0, done0, match0;
  logic [75:0]  stim0;
  logic [31:0]  sig0;
  logic [5:0]   nvec0;
  logic [150:0] y0;

  logic         ld_ready3, busy3, done3, match3;
  logic [75:0]  stim3;
  logic [31:0]  sig3;
  logic [5:0]   nvec3;
  logic [150:0] y3;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sig123;
  logic [31:0] sig230;

  assign y0 = {75'd0, stim0};

  always @(posedge clk) y3 <= {75'd0, stim3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stim_sig_engine #(.DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready0),
    .ld_data(ld_data), .ld_last(ld_last), .start(start), .gap_en(gap_en),
    .stim(stim0), .dut_y(y0), .expect_sig(expect0), .busy(busy0),
    .done(done0), .match(match0), .sig(sig0), .nvec(nvec0)
  );

  stim_sig_engine #(.DUT_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready3),
    .ld_data(ld_data), .ld_last(ld_last), .start(start), .gap_en(gap_en),
    .stim(stim3), .dut_y(y3), .expect_sig(expect3), .busy(busy3),
    .done(done3), .match(match3), .sig(sig3), .nvec(nvec3)
  );

  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [75:0] v);
    logic [150:0] y;
    logic [31:0]  f;
    y = {75'd0, v};
    for (int b = 0; b < 32; b++) begin
      f[b] = 1'b0;
      for (int p = b; p < 151; p += 32) f[b] = f[b] ^ y[p];
    end
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0000_0000) ^ f;
  endfunction

  task automatic beat(input logic [75:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic load123();
    beat(76'd1, 1'b0);
    beat(76'd2, 1'b0);
    beat(76'd3, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!(done0 && done3) && t < 60) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!(done0 && done3)) begin
      n_errors++;
      $display("FAIL %s_timeout done0=%0b done3=%0b exp both 1", name, done0, done3);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = 76'd0; ld_last = 1'b0;
    start = 1'b0; gap_en = 1'b0; expect0 = 32'd0; expect3 = 32'd0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (stim0 !== 76'd0) begin n_errors++; $display("FAIL rst_stim got %h exp 0", stim0); end
    n_checks++; if (sig0 !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL rst_sig got %h exp ffffffff", sig0); end
    n_checks++; if (nvec0 !== 6'd0) begin n_errors++; $display("FAIL rst_nvec got %0d exp 0", nvec0); end
    n_checks++; if ({busy0, done0, match0} !== 3'b000) begin n_errors++; $display("FAIL rst_status got %b exp 000", {busy0, done0, match0}); end
    n_checks++; if (ld_ready0 !== 1'b1) begin n_errors++; $display("FAIL rst_ld_ready got %b exp 1", ld_ready0); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_empty();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL empty_busy got %b exp 0", busy0); end
    @(negedge clk);
    n_checks++; if ({busy0, done0, stim0} !== {2'b00, 76'd0}) begin n_errors++; $display("FAIL empty_state got busy=%b done=%b stim=%h exp 0 0 0", busy0, done0, stim0); end
  endtask

  task automatic test_load3();
    load123();
    n_checks++; if (nvec0 !== 6'd3) begin n_errors++; $display("FAIL load3_nvec got %0d exp 3", nvec0); end
    n_checks++; if ({ld_ready0, busy0} !== 2'b10) begin n_errors++; $display("FAIL load3_ready_busy got %b exp 10", {ld_ready0, busy0}); end
  endtask

  task automatic test_run_nogap();
    logic [75:0] exp_s [7];
    exp_s = '{76'd1, 76'd1, 76'd2, 76'd2, 76'd3, 76'd3, 76'd0};
    expect0 = sig123 ^ 32'h0000_0001;
    expect3 = sig230;
    gap_en  = 1'b0;
    start   = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (stim0 !== exp_s[k]) begin n_errors++; $display("FAIL nogap_stim[%0d] got %h exp %h", k, stim0, exp_s[k]); end
    end
    n_checks++; if ({busy3, done3} !== 2'b10) begin n_errors++; $display("FAIL lat3_drain got busy=%b done=%b exp 1 0", busy3, done3); end
    wait_done("nogap");
    n_checks++; if (sig0 !== sig123) begin n_errors++; $display("FAIL nogap_sig0 got %h exp %h", sig0, sig123); end
    n_checks++; if ({busy0, done0, match0} !== 3'b010) begin n_errors++; $display("FAIL nogap_status0 got %b exp 010", {busy0, done0, match0}); end
    n_checks++; if (sig3 !== sig230) begin n_errors++; $display("FAIL nogap_sig3 got %h exp %h", sig3, sig230); end
    n_checks++; if (match3 !== 1'b1) begin n_errors++; $display("FAIL nogap_match3 got %b exp 1", match3); end
  endtask

  task automatic test_run_gap();
    logic [75:0] exp_s [9];
    exp_s = '{76'd1, 76'd1, 76'd0, 76'd2, 76'd2, 76'd0, 76'd3, 76'd3, 76'd0};
    expect0 = sig123;
    expect3 = sig230 ^ 32'h8000_0000;
    gap_en  = 1'b1;
    start   = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      start  = 1'b0;
      gap_en = 1'b0;
      n_checks++;
      if (stim0 !== exp_s[k]) begin n_errors++; $display("FAIL gap_stim[%0d] got %h exp %h", k, stim0, exp_s[k]); end
    end
    wait_done("gap");
    n_checks++; if (sig0 !== sig123) begin n_errors++; $display("FAIL gap_sig0 got %h exp %h", sig0, sig123); end
    n_checks++; if (match0 !== 1'b1) begin n_errors++; $display("FAIL gap_match0 got %b exp 1", match0); end
    n_checks++; if (sig3 !== sig230) begin n_errors++; $display("FAIL gap_sig3 got %h exp %h", sig3, sig230); end
    n_checks++; if (match3 !== 1'b0) begin n_errors++; $display("FAIL gap_match3 got %b exp 0", match3); end
  endtask

  task automatic test_start_with_load();
    ld_valid = 1'b1;
    ld_data  = 76'd5;
    start    = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
    start    = 1'b0;
    n_checks++; if ({busy0, done0, match0} !== 3'b000) begin n_errors++; $display("FAIL ldstart_status got %b exp 000", {busy0, done0, match0}); end
    n_checks++; if (nvec0 !== 6'd1) begin n_errors++; $display("FAIL ldstart_nvec got %0d exp 1", nvec0); end
    @(negedge clk);
    n_checks++; if ({busy0, stim0} !== {1'b0, 76'd0}) begin n_errors++; $display("FAIL ldstart_idle got busy=%b stim=%h exp 0 0", busy0, stim0); end
  endtask

  task automatic test_full_load();
    for (int i = 1; i < 32; i++) beat(76'(i + 100), 1'b0);
    n_checks++; if (nvec0 !== 6'd32) begin n_errors++; $display("FAIL full_nvec got %0d exp 32", nvec0); end
    n_checks++; if (ld_ready0 !== 1'b0) begin n_errors++; $display("FAIL full_ready got %b exp 0", ld_ready0); end
    ld_valid = 1'b1;
    ld_data  = 76'd77;
    @(negedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    n_checks++; if (nvec0 !== 6'd32) begin n_errors++; $display("FAIL full_extra_nvec got %0d exp 32", nvec0); end
  endtask

  task automatic test_reset_midrun();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load123();
    expect0 = sig123;
    start   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    n_checks++; if ({busy0, stim0} !== {1'b1, 76'd3}) begin n_errors++; $display("FAIL midrun_pre got busy=%b stim=%h exp 1 3", busy0, stim0); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({stim0, stim3} !== 152'd0) begin n_errors++; $display("FAIL midrun_stim got %h %h exp 0 0", stim0, stim3); end
    n_checks++; if ({busy0, done0, match0, busy3} !== 4'b0000) begin n_errors++; $display("FAIL midrun_status got %b exp 0000", {busy0, done0, match0, busy3}); end
    n_checks++; if ({sig0, nvec0, ld_ready0} !== {32'hFFFF_FFFF, 6'd0, 1'b1}) begin n_errors++; $display("FAIL midrun_regs got sig=%h nvec=%0d rdy=%b exp ffffffff 0 1", sig0, nvec0, ld_ready0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if ({busy0, nvec0, stim0} !== {1'b0, 6'd0, 76'd0}) begin n_errors++; $display("FAIL release_state got busy=%b nvec=%0d stim=%h exp 0 0 0", busy0, nvec0, stim0); end
    load123();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if ({busy0, stim0} !== {1'b1, 76'd1}) begin n_errors++; $display("FAIL replay_first got busy=%b stim=%h exp 1 1", busy0, stim0); end
    wait_done("replay");
    n_checks++; if (sig0 !== sig123) begin n_errors++; $display("FAIL replay_sig0 got %h exp %h", sig0, sig123); end
    n_checks++; if (match0 !== 1'b1) begin n_errors++; $display("FAIL replay_match0 got %b exp 1", match0); end
  endtask

  initial begin
    sig123 = m_step(m_step(m_step(32'hFFFF_FFFF, 76'd1), 76'd2), 76'd3);
    sig230 = m_step(m_step(m_step(32'hFFFF_FFFF, 76'd2), 76'd3), 76'd0);
    test_reset();
    test_start_empty();
    test_load3();
    test_run_nogap();
    test_run_gap();
    test_start_with_load();
    test_full_load();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
